// File: rtl/rom4001_resp.sv
// ROM-side responder for the 4-bit multiplexed CPU bus: tracks the 8-phase cycle,
// returns the fetched opcode in M1/M2 and implements the SRC-selected WRR/RDR port.
module rom4001_resp #(
   parameter logic [3:0] CHIP_ID = 4'h0,
   parameter logic [3:0] IO_DIR  = 4'h0
) (
   input  logic       CLK,
   input  logic       RES,
   input  logic       SYNC,
   input  logic       CM_ROM,
   input  logic [3:0] DATA_I,
   output logic [3:0] DATA_O,
   output logic       DATA_OE,
   output logic       rom_rd,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [3:0] io_in,
   output logic [3:0] io_out,
   output logic       sync_err
);

   localparam logic [3:0] PH_IDLE = 4'd0;
   localparam logic [3:0] PH_A1   = 4'd1;
   localparam logic [3:0] PH_A2   = 4'd2;
   localparam logic [3:0] PH_A3   = 4'd3;
   localparam logic [3:0] PH_M1   = 4'd4;
   localparam logic [3:0] PH_M2   = 4'd5;
   localparam logic [3:0] PH_X1   = 4'd6;
   localparam logic [3:0] PH_X2   = 4'd7;
   localparam logic [3:0] PH_X3   = 4'd8;

   localparam logic [3:0] OPR_IO  = 4'hE;
   localparam logic [3:0] OPA_WRR = 4'h2;
   localparam logic [3:0] OPA_RDR = 4'hA;

   logic [3:0] phase_q,    phase_d;
   logic [3:0] addr_lo_q,  addr_lo_d;
   logic [3:0] addr_mid_q, addr_mid_d;
   logic       selected_q, selected_d;
   // Only the low opcode nibble is held; the high nibble goes out straight from rom_data in M1.
   logic [3:0] opcode_q,   opcode_d;
   logic [3:0] opr_q,      opr_d;
   logic [3:0] opa_q,      opa_d;
   logic       io_cmd_q,   io_cmd_d;
   logic       src_sel_q,  src_sel_d;
   logic [3:0] io_out_q,   io_out_d;
   logic       sync_err_q, sync_err_d;

   logic       sync_bad;
   logic       cs_hit;
   logic       wrr_hit;
   logic       rdr_hit;
   logic       fetch_drive;
   logic [3:0] rdr_value;

   assign sync_bad  = SYNC && (phase_q != PH_IDLE) && (phase_q != PH_X3);
   assign cs_hit    = CM_ROM && (DATA_I == CHIP_ID);
   assign wrr_hit   = io_cmd_q && (opa_q == OPA_WRR) && src_sel_q;
   assign rdr_hit   = io_cmd_q && (opa_q == OPA_RDR) && src_sel_q;
   assign rdr_value = (io_in & ~IO_DIR) | (io_out_q & IO_DIR);

   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         PH_IDLE: if (SYNC) phase_d = PH_A1;
         PH_A1:   phase_d = PH_A2;
         PH_A2:   phase_d = PH_A3;
         PH_A3:   phase_d = PH_M1;
         PH_M1:   phase_d = PH_M2;
         PH_M2:   phase_d = PH_X1;
         PH_X1:   phase_d = PH_X2;
         PH_X2:   phase_d = PH_X3;
         PH_X3:   phase_d = SYNC ? PH_A1 : PH_IDLE;
         default: phase_d = PH_IDLE;
      endcase
      if (sync_bad) phase_d = PH_A1;
   end

   always_comb begin
      addr_lo_d  = addr_lo_q;
      addr_mid_d = addr_mid_q;
      selected_d = selected_q;
      opcode_d   = opcode_q;
      opr_d      = opr_q;
      opa_d      = opa_q;
      io_cmd_d   = io_cmd_q;
      src_sel_d  = src_sel_q;
      io_out_d   = io_out_q;
      sync_err_d = sync_bad;
      if (sync_bad) begin
         // A resync throws away everything gathered for the aborted instruction.
         addr_lo_d  = 4'h0;
         addr_mid_d = 4'h0;
         selected_d = 1'b0;
         opcode_d   = 4'h0;
         opr_d      = 4'h0;
         opa_d      = 4'h0;
         io_cmd_d   = 1'b0;
      end else begin
         case (phase_q)
            PH_A1: addr_lo_d  = DATA_I;
            PH_A2: addr_mid_d = DATA_I;
            PH_A3: selected_d = cs_hit;
            PH_M1: begin
               opcode_d = rom_data[3:0];
               opr_d    = DATA_I;
            end
            PH_M2: begin
               io_cmd_d = CM_ROM && (opr_q == OPR_IO);
               opa_d    = DATA_I;
            end
            PH_X2: begin
               if (CM_ROM && !io_cmd_q) src_sel_d = (DATA_I == CHIP_ID);
               if (wrr_hit) io_out_d = (DATA_I & IO_DIR) | (io_out_q & ~IO_DIR);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         phase_q    <= PH_IDLE;
         addr_lo_q  <= 4'h0;
         addr_mid_q <= 4'h0;
         selected_q <= 1'b0;
         opcode_q   <= 4'h0;
         opr_q      <= 4'h0;
         opa_q      <= 4'h0;
         io_cmd_q   <= 1'b0;
         src_sel_q  <= 1'b0;
         io_out_q   <= 4'h0;
         sync_err_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         addr_lo_q  <= addr_lo_d;
         addr_mid_q <= addr_mid_d;
         selected_q <= selected_d;
         opcode_q   <= opcode_d;
         opr_q      <= opr_d;
         opa_q      <= opa_d;
         io_cmd_q   <= io_cmd_d;
         src_sel_q  <= src_sel_d;
         io_out_q   <= io_out_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign fetch_drive = selected_q && ((phase_q == PH_M1) || (phase_q == PH_M2));

   always_comb begin
      DATA_O  = 4'h0;
      DATA_OE = 1'b0;
      if (!sync_bad) begin
         if (fetch_drive) begin
            DATA_OE = 1'b1;
            DATA_O  = (phase_q == PH_M1) ? rom_data[7:4] : opcode_q;
         end else if ((phase_q == PH_X2) && rdr_hit) begin
            DATA_OE = 1'b1;
            DATA_O  = rdr_value;
         end
      end
   end

   assign rom_rd   = (phase_q == PH_A3) && cs_hit;
   assign rom_addr = (phase_q == PH_A3) ? {addr_mid_q, addr_lo_q} : 8'h00;
   assign io_out   = io_out_q;
   assign sync_err = sync_err_q;

endmodule
